// File: rtl/cpu_trace_emitter_pkg.sv
// Shared types and constants for the CPU write-trace emitter: request types,
// ASCII punctuation, line state encoding and character helpers.
package cpu_trace_emitter_pkg;

   localparam logic [1:0]  TRACE_TYPE_GRF = 2'b01;
   localparam logic [1:0]  TRACE_TYPE_MEM = 2'b10;
   localparam logic [13:0] TIME_MAX       = 14'd9999;
   localparam int          BCD_DIGITS     = 4;

   localparam logic [7:0] ASCII_NUL    = 8'h00;
   localparam logic [7:0] ASCII_CARET  = 8'h5e;
   localparam logic [7:0] ASCII_AT     = 8'h40;
   localparam logic [7:0] ASCII_COLON  = 8'h3a;
   localparam logic [7:0] ASCII_DOLLAR = 8'h24;
   localparam logic [7:0] ASCII_STAR   = 8'h2a;
   localparam logic [7:0] ASCII_LT     = 8'h3c;
   localparam logic [7:0] ASCII_EQ     = 8'h3d;
   localparam logic [7:0] ASCII_HASH   = 8'h23;
   localparam logic [7:0] ASCII_SPACE  = 8'h20;

   // Each state names the character currently presented on the sink.
   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_CARET = 4'd1,
      ST_TIME  = 4'd2,
      ST_AT    = 4'd3,
      ST_PC    = 4'd4,
      ST_COLON = 4'd5,
      ST_SP1   = 4'd6,
      ST_TAG   = 4'd7,
      ST_GRF   = 4'd8,
      ST_ADDR  = 4'd9,
      ST_SP2   = 4'd10,
      ST_LT    = 4'd11,
      ST_EQ    = 4'd12,
      ST_SP3   = 4'd13,
      ST_DATA  = 4'd14,
      ST_HASH  = 4'd15
   } trace_state_e;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] res;
      if (nib < 4'd10) begin
         res = {4'h3, nib};
      end else begin
         res = 8'h57 + {4'h0, nib};
      end
      return res;
   endfunction

   function automatic logic [7:0] dec_ascii(input logic [3:0] digit);
      return {4'h3, digit};
   endfunction

endpackage

// File: rtl/cpu_trace_emitter_bin2bcd.sv
// Combinational 14-bit binary to 4-digit BCD (shift-add-3) with the digit count
// of the leading-zero-suppressed value. Inputs above 9999 are not representable.
module bin2bcd_14
   import cpu_trace_emitter_pkg::*;
(
   input  logic [13:0] bin,
   output logic [15:0] bcd,
   output logic [2:0]  ndigits
);

   logic [15:0] acc_s;

   // Double-dabble: correct each BCD digit >= 5 before shifting in the next bit.
   always_comb begin
      acc_s = 16'd0;
      for (int i = 13; i >= 0; i--) begin
         for (int d = 0; d < BCD_DIGITS; d++) begin
            if (acc_s[4*d +: 4] >= 4'd5) begin
               acc_s[4*d +: 4] = acc_s[4*d +: 4] + 4'd3;
            end else begin
               acc_s[4*d +: 4] = acc_s[4*d +: 4];
            end
         end
         acc_s = {acc_s[14:0], bin[i]};
      end
   end

   // Count significant digits; zero still occupies one digit.
   always_comb begin
      if (acc_s[15:12] != 4'd0) begin
         ndigits = 3'd4;
      end else if (acc_s[11:8] != 4'd0) begin
         ndigits = 3'd3;
      end else if (acc_s[7:4] != 4'd0) begin
         ndigits = 3'd2;
      end else begin
         ndigits = 3'd1;
      end
   end

   assign bcd = acc_s;

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU register/memory write event into an ASCII trace line,
// one character per sink handshake.
module cpu_trace_emitter
   import cpu_trace_emitter_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 0
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_type,
   input  logic [13:0] req_time,
   input  logic [31:0] req_pc,
   input  logic [4:0]  req_grf,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic [7:0]  char,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        line_done,
   output logic [1:0]  err
);

   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

   trace_state_e state_r;
   trace_state_e nxt_state_s;
   logic [2:0]   k_r;
   logic [2:0]   nxt_k_s;
   logic [7:0]   nxt_char_s;

   logic [1:0]   type_r;
   logic [13:0]  time_r;
   logic [31:0]  pc_r;
   logic [4:0]   grf_r;
   logic [31:0]  addr_r;
   logic [31:0]  data_r;
   logic [3:0]   gap_r;

   logic [7:0]   char_r;
   logic         char_valid_r;
   logic         line_done_r;
   logic [1:0]   err_r;

   logic         accept_s;
   logic         advance_s;
   logic         step_s;
   logic         legal_s;
   logic         time_sat_s;

   logic [15:0]  time_bcd_s;
   logic [2:0]   time_nd_s;
   logic [15:0]  grf_bcd_s;
   logic [2:0]   grf_nd_s;

   bin2bcd_14 u_time_bcd (
      .bin     (time_r),
      .bcd     (time_bcd_s),
      .ndigits (time_nd_s)
   );

   bin2bcd_14 u_grf_bcd (
      .bin     ({9'd0, grf_r}),
      .bcd     (grf_bcd_s),
      .ndigits (grf_nd_s)
   );

   assign req_ready  = (state_r == ST_IDLE) && (gap_r == 4'd0) && !reset;
   assign accept_s   = req_valid && req_ready;
   assign advance_s  = (state_r != ST_IDLE) && char_valid_r && char_ready;
   assign step_s     = accept_s || advance_s;
   assign legal_s    = (req_type == TRACE_TYPE_GRF) || (req_type == TRACE_TYPE_MEM);
   assign time_sat_s = (req_time > TIME_MAX);

   // Next position in the line; digit fields count k down to 0.
   always_comb begin
      nxt_state_s = state_r;
      nxt_k_s     = k_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && legal_s) begin
               nxt_state_s = ST_CARET;
               nxt_k_s     = 3'd0;
            end else begin
               nxt_state_s = ST_IDLE;
               nxt_k_s     = 3'd0;
            end
         end
         ST_CARET: begin
            nxt_state_s = ST_TIME;
            nxt_k_s     = time_nd_s - 3'd1;
         end
         ST_TIME: begin
            if (k_r != 3'd0) begin
               nxt_k_s = k_r - 3'd1;
            end else begin
               nxt_state_s = ST_AT;
            end
         end
         ST_AT: begin
            nxt_state_s = ST_PC;
            nxt_k_s     = 3'd7;
         end
         ST_PC: begin
            if (k_r != 3'd0) begin
               nxt_k_s = k_r - 3'd1;
            end else begin
               nxt_state_s = ST_COLON;
            end
         end
         ST_COLON: nxt_state_s = ST_SP1;
         ST_SP1:   nxt_state_s = ST_TAG;
         ST_TAG: begin
            if (type_r == TRACE_TYPE_GRF) begin
               nxt_state_s = ST_GRF;
               nxt_k_s     = grf_nd_s - 3'd1;
            end else begin
               nxt_state_s = ST_ADDR;
               nxt_k_s     = 3'd7;
            end
         end
         ST_GRF, ST_ADDR: begin
            if (k_r != 3'd0) begin
               nxt_k_s = k_r - 3'd1;
            end else begin
               nxt_state_s = ST_SP2;
            end
         end
         ST_SP2: nxt_state_s = ST_LT;
         ST_LT:  nxt_state_s = ST_EQ;
         ST_EQ:  nxt_state_s = ST_SP3;
         ST_SP3: begin
            nxt_state_s = ST_DATA;
            nxt_k_s     = 3'd7;
         end
         ST_DATA: begin
            if (k_r != 3'd0) begin
               nxt_k_s = k_r - 3'd1;
            end else begin
               nxt_state_s = ST_HASH;
            end
         end
         ST_HASH: begin
            nxt_state_s = ST_IDLE;
            nxt_k_s     = 3'd0;
         end
         default: begin
            nxt_state_s = ST_IDLE;
            nxt_k_s     = 3'd0;
         end
      endcase
   end

   // Character for the next position, so char can be loaded into a register.
   always_comb begin
      nxt_char_s = ASCII_NUL;
      case (nxt_state_s)
         ST_IDLE:  nxt_char_s = ASCII_NUL;
         ST_CARET: nxt_char_s = ASCII_CARET;
         ST_TIME:  nxt_char_s = dec_ascii(time_bcd_s[{nxt_k_s[1:0], 2'b00} +: 4]);
         ST_AT:    nxt_char_s = ASCII_AT;
         ST_PC:    nxt_char_s = hex_ascii(pc_r[{nxt_k_s, 2'b00} +: 4]);
         ST_COLON: nxt_char_s = ASCII_COLON;
         ST_SP1:   nxt_char_s = ASCII_SPACE;
         ST_TAG:   nxt_char_s = (type_r == TRACE_TYPE_GRF) ? ASCII_DOLLAR : ASCII_STAR;
         ST_GRF:   nxt_char_s = dec_ascii(grf_bcd_s[{nxt_k_s[1:0], 2'b00} +: 4]);
         ST_ADDR:  nxt_char_s = hex_ascii(addr_r[{nxt_k_s, 2'b00} +: 4]);
         ST_SP2:   nxt_char_s = ASCII_SPACE;
         ST_LT:    nxt_char_s = ASCII_LT;
         ST_EQ:    nxt_char_s = ASCII_EQ;
         ST_SP3:   nxt_char_s = ASCII_SPACE;
         ST_DATA:  nxt_char_s = hex_ascii(data_r[{nxt_k_s, 2'b00} +: 4]);
         ST_HASH:  nxt_char_s = ASCII_HASH;
         default:  nxt_char_s = ASCII_NUL;
      endcase
   end

   // Line FSM, captured request fields, gap counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         k_r          <= 3'd0;
         type_r       <= 2'b00;
         time_r       <= 14'd0;
         pc_r         <= 32'd0;
         grf_r        <= 5'd0;
         addr_r       <= 32'd0;
         data_r       <= 32'd0;
         gap_r        <= 4'd0;
         char_r       <= ASCII_NUL;
         char_valid_r <= 1'b0;
         line_done_r  <= 1'b0;
         err_r        <= 2'b00;
      end else begin
         line_done_r <= 1'b0;
         err_r       <= 2'b00;
         if (accept_s) begin
            type_r <= req_type;
            time_r <= time_sat_s ? TIME_MAX : req_time;
            pc_r   <= req_pc;
            grf_r  <= req_grf;
            addr_r <= req_addr;
            data_r <= req_data;
            err_r  <= {time_sat_s, ~legal_s};
         end
         if (step_s) begin
            state_r      <= nxt_state_s;
            k_r          <= nxt_k_s;
            char_r       <= nxt_char_s;
            char_valid_r <= (nxt_state_s != ST_IDLE);
         end
         if ((state_r == ST_HASH) && advance_s) begin
            line_done_r <= 1'b1;
            gap_r       <= GAP_LOAD;
         end else if ((state_r == ST_IDLE) && (gap_r != 4'd0)) begin
            gap_r <= gap_r - 4'd1;
         end
      end
   end

   assign char       = char_r;
   assign char_valid = char_valid_r;
   assign line_done  = line_done_r;
   assign err        = err_r;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed self-checking bench for cpu_trace_emitter: expected trace lines are
// written out by hand and compared character by character.
module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_type;
   logic [13:0] req_time;
   logic [31:0] req_pc;
   logic [4:0]  req_grf;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [7:0]  char;
   logic        char_valid;
   logic        char_ready;
   logic        line_done;
   logic [1:0]  err;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [7:0]  cap_q[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_char  = 8'h00;

   cpu_trace_emitter #(.GAP_CYCLES(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_type   (req_type),
      .req_time   (req_time),
      .req_pc     (req_pc),
      .req_grf    (req_grf),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .char       (char),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .line_done  (line_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sink side: record accepted characters and verify hold behaviour during stalls.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", {31'd0, char_valid}, 32'd1);
            chk("hold_char", {24'd0, char}, {24'd0, prev_char});
         end
         if (char_valid && char_ready) cap_q.push_back(char);
         prev_stall = char_valid && !char_ready;
         prev_char  = char;
      end
   end

   task automatic send(input logic [1:0] t, input logic [13:0] tm, input logic [31:0] pc,
                       input logic [4:0] g, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] exp_err);
      int   w = 0;
      logic legal;
      while (!req_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      cap_q.delete();
      req_type  = t;
      req_time  = tm;
      req_pc    = pc;
      req_grf   = g;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      legal = (t == 2'b01) || (t == 2'b10);
      chk("err_pulse", {30'd0, err}, {30'd0, exp_err});
      chk("first_valid", {31'd0, char_valid}, {31'd0, legal});
      chk("first_char", {24'd0, char}, legal ? 32'h5e : 32'h00);
   endtask

   task automatic run_line(input string name, input string exp, input bit stall);
      bit done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         char_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         if (c == 0) chk({name, "_err_clear"}, {30'd0, err}, 32'd0);
         if (line_done) done = 1'b1;
      end
      char_ready = 1'b1;
      chk({name, "_done"}, {31'd0, done}, 32'd1);
      chk({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
      chk({name, "_valid_drop"}, {31'd0, char_valid}, 32'd0);
      @(posedge clk); #1;
      chk({name, "_ld_one_cycle"}, {31'd0, line_done}, 32'd0);
      chk({name, "_len"}, cap_q.size(), exp.len());
      for (int i = 0; i < exp.len() && i < cap_q.size(); i++)
         chk($sformatf("%s_c%0d", name, i), {24'd0, cap_q[i]}, {24'd0, exp[i]});
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_type   = 2'b00;
      req_time   = 14'd0;
      req_pc     = 32'd0;
      req_grf    = 5'd0;
      req_addr   = 32'd0;
      req_data   = 32'd0;
      char_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_char_valid", {31'd0, char_valid}, 32'd0);
      chk("rst_char", {24'd0, char}, 32'd0);
      chk("rst_line_done", {31'd0, line_done}, 32'd0);
      chk("rst_err", {30'd0, err}, 32'd0);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

      send(2'b01, 14'd12, 32'h0000_3000, 5'd3, 32'd0, 32'h0000_abcd, 2'b00);
      run_line("reg", "^12@00003000: $3 <= 0000abcd#", 1'b0);

      send(2'b10, 14'd0, 32'h0000_3004, 5'd0, 32'h0000_0010, 32'h1234_5678, 2'b00);
      run_line("mem", "^0@00003004: *00000010 <= 12345678#", 1'b0);

      send(2'b10, 14'd7, 32'h0000_3008, 5'd0, 32'hdead_beef, 32'h0bad_f00d, 2'b00);
      run_line("stall", "^7@00003008: *deadbeef <= 0badf00d#", 1'b1);

      send(2'b01, 14'd16383, 32'h0000_0400, 5'd31, 32'd0, 32'hffff_ffff, 2'b10);
      run_line("sat", "^9999@00000400: $31 <= ffffffff#", 1'b0);

      send(2'b01, 14'd9999, 32'h89ab_cdef, 5'd10, 32'd0, 32'd0, 2'b00);
      run_line("max", "^9999@89abcdef: $10 <= 00000000#", 1'b0);

      send(2'b11, 14'd5, 32'h0000_3010, 5'd1, 32'd0, 32'd1, 2'b01);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("ill_no_valid", {31'd0, char_valid}, 32'd0);
         chk("ill_err_once", {30'd0, err}, 32'd0);
      end
      chk("ill_no_chars", cap_q.size(), 32'd0);

      send(2'b00, 14'd10000, 32'h0000_3014, 5'd2, 32'd0, 32'd2, 2'b11);
      @(posedge clk); #1;
      chk("ill0_no_valid", {31'd0, char_valid}, 32'd0);

      send(2'b01, 14'd100, 32'h0000_1234, 5'd0, 32'd0, 32'd0, 2'b00);
      run_line("after_ill", "^100@00001234: $0 <= 00000000#", 1'b0);

      send(2'b10, 14'd3, 32'h0000_3000, 5'd0, 32'h0000_0020, 32'd1, 2'b00);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("mid_pc_valid", {31'd0, char_valid}, 32'd1);
      chk("mid_pc_char", {24'd0, char}, 32'h30);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_valid", {31'd0, char_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("mid_rst_ready_after", {31'd0, req_ready}, 32'd1);

      send(2'b01, 14'd42, 32'h0000_300c, 5'd7, 32'd0, 32'hcafe_f00d, 2'b00);
      run_line("post_rst", "^42@0000300c: $7 <= cafef00d#", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
